// File: rtl/csa_resolve_adder.sv
// csa_resolve_adder
//   Resolves a redundant (sum, carry) pair from a carry-save tree into a
//   binary result, CHUNK bits per cycle, LSB chunk first. A single operation
//   is in flight at a time: IDLE accepts, ADD ripples the chunks, and DONE
//   holds the result until the consumer takes it.
//
// Parameters
//   WIDTH  operand/result width (multiple of CHUNK)
//   CHUNK  bits resolved per ADD cycle
//   TAG_W  reservation-station tag width
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous discard of the in-flight operation
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_sum, in_carry    redundant operand pair (carry already weight-aligned)
//   in_tag              tag travelling with the operation
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_result          (in_sum + in_carry) mod 2^WIDTH
//   out_tag             tag captured at accept
//   out_cout            carry out of bit WIDTH-1 (only with CSA_RESOLVE_COUT_EN)
//
// Build option
//   CSA_RESOLVE_COUT_EN  adds the out_cout port; without it the final
//                        running carry is dropped.

module csa_resolve_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef CSA_RESOLVE_COUT_EN
  output logic             out_cout,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e state_q, state_d;

  // Operands and result viewed as arrays of chunks so the active chunk is a
  // plain index by idx_q.
  logic [NCHUNK-1:0][CHUNK-1:0] sum_q, sum_d;
  logic [NCHUNK-1:0][CHUNK-1:0] carry_q, carry_d;
  logic [NCHUNK-1:0][CHUNK-1:0] result_q, result_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         rc_q, rc_d;

  logic [CHUNK:0]               chunk_sum;
  logic                         last_chunk;

`ifdef CSA_RESOLVE_COUT_EN
  logic cout_q, cout_d;
`endif

  // One CHUNK-wide adder, reused every ADD cycle.
  assign chunk_sum  = {1'b0, sum_q[idx_q]} + {1'b0, carry_q[idx_q]} + {{CHUNK{1'b0}}, rc_q};
  assign last_chunk = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    rc_d     = rc_q;
`ifdef CSA_RESOLVE_COUT_EN
    cout_d   = cout_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Operands are only captured here, so later input wiggles cannot
        // disturb an operation already in flight.
        if (in_valid && !flush) begin
          sum_d   = in_sum;
          carry_d = in_carry;
          tag_d   = in_tag;
          idx_d   = '0;
          rc_d    = 1'b0;
`ifdef CSA_RESOLVE_COUT_EN
          cout_d  = 1'b0;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        result_d[idx_q] = chunk_sum[CHUNK-1:0];
        rc_d            = chunk_sum[CHUNK];
        idx_d           = idx_q + 1'b1;
        if (last_chunk) begin
`ifdef CSA_RESOLVE_COUT_EN
          cout_d  = chunk_sum[CHUNK];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over both accept and the output handshake.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      rc_q     <= 1'b0;
`ifdef CSA_RESOLVE_COUT_EN
      cout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      rc_q     <= rc_d;
`ifdef CSA_RESOLVE_COUT_EN
      cout_q   <= cout_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;
`ifdef CSA_RESOLVE_COUT_EN
  assign out_cout   = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb_csa_resolve_adder
//   Directed, table-driven bench for csa_resolve_adder at default parameters,
//   plus hand-written sequences for backpressure, flush, mid-operation reset
//   and back-to-back random operations. Define CSA_RESOLVE_COUT_EN to also
//   exercise out_cout.

module tb_csa_resolve_adder;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int TAG_W  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  // Accept-to-accept spacing with out_ready high: one IDLE cycle, NCHUNK ADD
  // cycles, one DONE cycle.
  localparam int PERIOD = NCHUNK + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_carry = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
`ifdef CSA_RESOLVE_COUT_EN
  logic             out_cout;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  csa_resolve_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef CSA_RESOLVE_COUT_EN
    .out_cout   (out_cout),
`endif
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [3:0]  t;
    logic [63:0] r;
    logic        co;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_cout();
`ifdef CSA_RESOLVE_COUT_EN
    return out_cout;
`else
    return 1'b0;
`endif
  endfunction

  // Offer one operand pair on the next falling edge, then wait (bounded) for
  // the result. Inputs are scrambled after accept to show they are ignored.
  task automatic do_op(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t,
                       input string name,
                       output logic [63:0] r, output logic [3:0] tg, output logic co,
                       output int lat, output int acc_cyc);
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_tag = t;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_sum = ~s; in_carry = s; in_tag = ~t;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r  = out_result;
    tg = out_tag;
    co = get_cout();
  endtask

  initial begin
    logic [63:0] r, s, c;
    logic [3:0]  tg, t;
    logic        co;
    int          lat, acc, prev_acc, w;
    bit          seen;

    // sum, carry, tag, result, cout
    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 4'h3, 64'h0000_0000_0001_0000, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h1, 64'h0, 1'b1};
    vecs[2] = '{64'h5, 64'hA, 4'h2, 64'hF, 1'b0};
    vecs[3] = '{64'h1234, 64'h1, 4'h4, 64'h1235, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h5, 64'h0, 1'b1};
    vecs[5] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 4'h6, 64'h0001_0000_0000_0000, 1'b0};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'h7, 64'h2222_2222_2222_2211, 1'b0};
    vecs[7] = '{64'h0, 64'h0, 4'hF, 64'h0, 1'b0};
    vecs[8] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    // Reset state
    #3;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    out_result,     64'd0);
    chk("rst_tag",       64'(out_tag),   64'd0);
`ifdef CSA_RESOLVE_COUT_EN
    chk("rst_cout",      64'(out_cout),  64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].s, vecs[i].c, vecs[i].t, $sformatf("vec%0d", i), r, tg, co, lat, acc);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NCHUNK));
      chk($sformatf("vec%0d_result", i), r, vecs[i].r);
      chk($sformatf("vec%0d_tag", i), 64'(tg), 64'(vecs[i].t));
`ifdef CSA_RESOLVE_COUT_EN
      chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].co));
`endif
    end

    // Backpressure: result held while out_ready=0 and new data is offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 64'h100; in_carry = 64'h200; in_tag = 4'h7;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_latency", 64'(w), 64'(NCHUNK));
    in_valid = 1'b1; in_sum = 64'hDEAD; in_carry = 64'h1; in_tag = 4'h9;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_valid", k),  64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_result", k), out_result,      64'h300);
      chk($sformatf("bp_hold%0d_tag", k),    64'(out_tag),   64'h7);
      chk($sformatf("bp_hold%0d_ready", k),  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_4th_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_after_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_next_latency", 64'(w), 64'(NCHUNK));
    chk("bp_next_result",  out_result, 64'hDEAE);
    chk("bp_next_tag",     64'(out_tag), 64'h9);

    // Flush in the second ADD cycle
    @(negedge clk);
    in_valid = 1'b1; in_sum = 64'hFFFF; in_carry = 64'h1; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_never_valid", 64'(seen), 64'd0);
    do_op(64'h5, 64'hA, 4'hC, "post_flush", r, tg, co, lat, acc);
    chk("post_flush_latency", 64'(lat), 64'(NCHUNK));
    chk("post_flush_result",  r, 64'hF);
    chk("post_flush_tag",     64'(tg), 64'hC);

    // Reset pulsed during ADD (chunk 0 already written, so out_result != 0)
    @(negedge clk);
    in_valid = 1'b1; in_sum = 64'h1111_1111; in_carry = 64'h2222; in_tag = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result",    out_result,     64'd0);
    chk("midrst_tag",       64'(out_tag),   64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(64'h1234, 64'h1, 4'h8, "post_rst", r, tg, co, lat, acc);
    chk("post_rst_latency", 64'(lat), 64'(NCHUNK));
    chk("post_rst_result",  r, 64'h1235);
    chk("post_rst_tag",     64'(tg), 64'h8);

    // Random back-to-back operations with out_ready held high
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      s = {$urandom, $urandom};
      c = {$urandom, $urandom};
      t = 4'($urandom_range(15));
      do_op(s, c, t, $sformatf("rnd%0d", i), r, tg, co, lat, acc);
      chk($sformatf("rnd%0d_result", i), r, s + c);
      chk($sformatf("rnd%0d_tag", i), 64'(tg), 64'(t));
      if (i > 0) chk($sformatf("rnd%0d_period", i), 64'(acc - prev_acc), 64'(PERIOD));
      prev_acc = acc;
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
